icb_nmxs_rr: RTL and testbench
==============================

# icb_nmxs_rr

Parametrised N-master / M-slave ICB interconnect: the next generation of the fixed 2-master/8-slave bus bridge in the SoC top level. Masters (JTAG, core, future DMA) are arbitrated round-robin onto one shared bus. The upper address bits are decoded to select a slave. Unmapped addresses and stalled slaves get an error response generated locally, so a bad access can no longer hang the core. One transaction is in flight at a time.

## Interface
Parameters:
- N_MST, 2, number of masters (1..8)
- N_SLV, 8, number of slaves (1..16)
- SEL_LSB, 28, LSB of the slave-select field in the address
- SEL_W, 4, width of the slave-select field; `2**SEL_W >= N_SLV`
- TIMEOUT, 1024, maximum cycles a slave may hold cmd_ready low before an error is returned; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- m_icb_cmd_valid / m_icb_cmd_ready  in / out  N_MST  per-master command handshake
- m_icb_cmd_addr  in  N_MST*32  flattened; master i is at bits [32i+31:32i]
- m_icb_cmd_read  in  N_MST  1 = read
- m_icb_cmd_wdata  in  N_MST*32  write data
- m_icb_cmd_wmask  in  N_MST*4  byte write mask
- m_icb_rsp_valid / m_icb_rsp_ready  out / in  N_MST  per-master response handshake
- m_icb_rsp_err  out  N_MST  error flag
- m_icb_rsp_rdata  out  N_MST*32  read data
- s_icb_cmd_valid / s_icb_cmd_ready  out / in  N_SLV  per-slave command handshake
- s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask  out  N_SLV*{32,1,32,4}  command broadcast to every slave
- s_icb_rsp_valid / s_icb_rsp_ready  in / out  N_SLV  per-slave response handshake
- s_icb_rsp_err  in  N_SLV  slave error flag
- s_icb_rsp_rdata  in  N_SLV*32  slave read data

## Operation
- FSM has four states: IDLE, CMD, RSP, ERR. Reset state is IDLE. Registers `gnt` (master index) and `sel` (slave index) both reset to 0. Round-robin pointer `ptr` resets to 0.
- IDLE: if any m_cmd_valid is high, pick the first requesting master scanning ptr, ptr+1, … (mod N_MST). Latch it into `gnt`. Latch its `addr[SEL_LSB+:SEL_W]` into `sel`. Go to CMD.
- CMD, mapped slave (sel < N_SLV):
  - s_cmd_valid[sel] = m_cmd_valid[gnt]; s_cmd_ready[sel] is routed back to m_cmd_ready[gnt].
  - Handshake completes → RSP.
- CMD, unmapped slave (sel >= N_SLV): assert m_cmd_ready[gnt] for one cycle, then → ERR.
- CMD, m_cmd_valid[gnt] drops without a handshake (protocol violation): → IDLE. Nothing is issued and ptr is unchanged.
- CMD, timeout: the wait counter counts cycles spent in CMD. On reaching TIMEOUT-1 without s_cmd_ready:
  - s_cmd_valid is forced low;
  - m_cmd_ready[gnt] is asserted for one cycle;
  - → ERR.
- RSP: slave response is routed straight through. m_rsp_valid[gnt] = s_rsp_valid[sel]; err and rdata pass through; s_rsp_ready[sel] = m_rsp_ready[gnt]. On the response handshake: ptr ← (gnt+1) mod N_MST, → IDLE.
- ERR: m_rsp_valid[gnt]=1, m_rsp_err=1, m_rsp_rdata=0. On m_rsp_ready: ptr ← gnt+1, → IDLE.
- All ungranted outputs are 0: valid, ready, err, rdata.
- Command payload is broadcast to every slave. Only s_cmd_valid is qualified per slave.

## Timing
- Reset values: every m_* output and s_*_valid / s_*_ready is 0. Counter is 0.
- Response and command ready are combinational through the FSM. Grant is registered.
- Minimum transaction is 3 cycles: IDLE (arbitrate), CMD (slave ready the same cycle), RSP (rsp_valid the same cycle). Back-to-back throughput is one transaction per 3 cycles.
- An unmapped access also takes 3 cycles: IDLE, CMD (ready), ERR.
- The wait counter clears on entry to CMD. It does not run in RSP; response stalls are unbounded.
- A request raised in RSP or ERR is arbitrated in the next IDLE cycle.
- N_MST=1: ptr is held at 0.
- When rst_n is asserted mid-transaction, the FSM returns to IDLE immediately. An in-flight slave transaction is abandoned; slaves share the same rst_n.

## Structure
- ICB address/data widths come from the `MemAddrBus` / `MemBus` defines in `defines.v`. Add a `ICB_TIMEOUT_DEF` define there.
- FSM state encodings are local parameters.
- Sub-module `icb_rr_arb`: combinational round-robin picker. Inputs: req vector and ptr. Output: gnt index.
- The module replaces `icb_2m8s` in the SoC top, instantiated with N_MST=2, N_SLV=8.

## Test plan
- Single read: m1 reads 0x1000_0004; slave 1 ready and responds rdata=0xDEADBEEF in the same cycle → m1 receives 0xDEADBEEF, err=0, in the 3rd cycle after the request.
- Round-robin fairness: m0 and m1 request continuously to slave 0 → grants alternate 0,1,0,1; no master is granted twice in a row.
- Unmapped address: N_SLV=8, read 0x9000_0000 → cmd_ready pulses for one cycle, then rsp err=1 and rdata=0; no s_cmd_valid is ever asserted.
- Timeout: TIMEOUT=16, slave 2 holds cmd_ready=0 → s_cmd_valid is high for exactly 16 cycles, then the master gets err=1.
- Response backpressure: master holds rsp_ready=0 for 5 cycles → rsp_valid and rdata stay stable, s_rsp_ready stays 0; the transaction completes on the 6th cycle.
- Reset mid-RSP: assert rst_n=0 while in RSP → all outputs are 0 asynchronously; after release, the first request is granted to m0.

Source files
------------

// File: rtl/icb_nmxs_rr_pkg.sv
// Shared types and constants for the N-master / M-slave ICB interconnect.
package icb_nmxs_rr_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int MASK_W          = DATA_W / 8;
    localparam int ICB_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_ERR  = 2'd3
    } icb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } icb_cmd_t;

    // Round-robin successor of index g among n entries.
    function automatic int rr_inc(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/icb_nmxs_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr.
module icb_rr_arb #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt
);

    logic found;

    // Scan ptr, ptr+1, ... (mod N); the first set request wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + k) % N)) begin
                    gnt   = PW'(j);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/icb_nmxs_rr.sv
// N-master / M-slave ICB interconnect, one transaction in flight, with
// local error responses for unmapped addresses and stalled slaves.
module icb_nmxs_rr
    import icb_nmxs_rr_pkg::*;
#(
    parameter int N_MST   = 2,
    parameter int N_SLV   = 8,
    parameter int SEL_LSB = 28,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = ICB_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_MST-1:0]          m_icb_cmd_valid,
    output logic [N_MST-1:0]          m_icb_cmd_ready,
    input  logic [N_MST*ADDR_W-1:0]   m_icb_cmd_addr,
    input  logic [N_MST-1:0]          m_icb_cmd_read,
    input  logic [N_MST*DATA_W-1:0]   m_icb_cmd_wdata,
    input  logic [N_MST*MASK_W-1:0]   m_icb_cmd_wmask,
    output logic [N_MST-1:0]          m_icb_rsp_valid,
    input  logic [N_MST-1:0]          m_icb_rsp_ready,
    output logic [N_MST-1:0]          m_icb_rsp_err,
    output logic [N_MST*DATA_W-1:0]   m_icb_rsp_rdata,
    output logic [N_SLV-1:0]          s_icb_cmd_valid,
    input  logic [N_SLV-1:0]          s_icb_cmd_ready,
    output logic [N_SLV*ADDR_W-1:0]   s_icb_cmd_addr,
    output logic [N_SLV-1:0]          s_icb_cmd_read,
    output logic [N_SLV*DATA_W-1:0]   s_icb_cmd_wdata,
    output logic [N_SLV*MASK_W-1:0]   s_icb_cmd_wmask,
    input  logic [N_SLV-1:0]          s_icb_rsp_valid,
    output logic [N_SLV-1:0]          s_icb_rsp_ready,
    input  logic [N_SLV-1:0]          s_icb_rsp_err,
    input  logic [N_SLV*DATA_W-1:0]   s_icb_rsp_rdata
);

    localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int CW = $clog2(TIMEOUT + 2);

    icb_state_e                   state;
    logic [PW-1:0]                gnt, ptr, arb_gnt, nxt_ptr;
    logic [SEL_W-1:0]             sel, arb_sel;
    logic [CW-1:0]                cnt;
    icb_cmd_t                     cmd;
    logic                         mv, mr_rdy;
    logic                         s_rdy, s_vld, s_err;
    logic [DATA_W-1:0]            s_rd;
    logic                         mapped, tmo;
    logic                         g_cmd_rdy, g_rsp_vld, g_rsp_err;
    logic [DATA_W-1:0]            g_rsp_rdata;
    logic                         sl_cmd_vld, sl_rsp_rdy;
    logic [N_MST-1:0][DATA_W-1:0] m_rdata;

    icb_rr_arb #(.N(N_MST), .PW(PW)) u_arb (
        .req (m_icb_cmd_valid),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    assign mapped  = int'(sel) < N_SLV;
    // Timeout fires once the counter has passed TIMEOUT-1 without a slave ready.
    assign tmo     = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
    assign nxt_ptr = PW'(rr_inc(int'(gnt), N_MST));

    // Gather the granted master's signals and the slave field of the arbitration winner.
    always_comb begin
        mv      = 1'b0;
        mr_rdy  = 1'b0;
        cmd     = '0;
        arb_sel = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (gnt == PW'(i)) begin
                mv        = m_icb_cmd_valid[i];
                mr_rdy    = m_icb_rsp_ready[i];
                cmd.addr  = m_icb_cmd_addr[ADDR_W*i +: ADDR_W];
                cmd.read  = m_icb_cmd_read[i];
                cmd.wdata = m_icb_cmd_wdata[DATA_W*i +: DATA_W];
                cmd.wmask = m_icb_cmd_wmask[MASK_W*i +: MASK_W];
            end
            if (arb_gnt == PW'(i))
                arb_sel = m_icb_cmd_addr[ADDR_W*i + SEL_LSB +: SEL_W];
        end
    end

    // Gather the selected slave's signals; an unmapped sel matches nothing.
    always_comb begin
        s_rdy = 1'b0;
        s_vld = 1'b0;
        s_err = 1'b0;
        s_rd  = '0;
        for (int s = 0; s < N_SLV; s++) begin
            if (int'(sel) == s) begin
                s_rdy = s_icb_cmd_ready[s];
                s_vld = s_icb_rsp_valid[s];
                s_err = s_icb_rsp_err[s];
                s_rd  = s_icb_rsp_rdata[DATA_W*s +: DATA_W];
            end
        end
    end

    // Per-state routing between the granted master and the selected slave.
    always_comb begin
        g_cmd_rdy   = 1'b0;
        g_rsp_vld   = 1'b0;
        g_rsp_err   = 1'b0;
        g_rsp_rdata = '0;
        sl_cmd_vld  = 1'b0;
        sl_rsp_rdy  = 1'b0;
        case (state)
            ST_CMD: begin
                if (mapped && !tmo) begin
                    sl_cmd_vld = mv;
                    g_cmd_rdy  = s_rdy;
                end else begin
                    // Accept locally; the error response follows in ERR.
                    g_cmd_rdy  = 1'b1;
                end
            end
            ST_RSP: begin
                g_rsp_vld   = s_vld;
                g_rsp_err   = s_err;
                g_rsp_rdata = s_rd;
                sl_rsp_rdy  = mr_rdy;
            end
            ST_ERR: begin
                g_rsp_vld = 1'b1;
                g_rsp_err = 1'b1;
            end
            default: ;
        endcase
    end

    // Fan grant-level signals out to the granted master only.
    always_comb begin
        m_icb_cmd_ready = '0;
        m_icb_rsp_valid = '0;
        m_icb_rsp_err   = '0;
        m_rdata         = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (gnt == PW'(i)) begin
                m_icb_cmd_ready[i] = g_cmd_rdy;
                m_icb_rsp_valid[i] = g_rsp_vld;
                m_icb_rsp_err[i]   = g_rsp_err;
                m_rdata[i]         = g_rsp_rdata;
            end
        end
    end

    // Fan slave-side handshakes out to the selected slave only.
    always_comb begin
        s_icb_cmd_valid = '0;
        s_icb_rsp_ready = '0;
        for (int s = 0; s < N_SLV; s++) begin
            if (int'(sel) == s) begin
                s_icb_cmd_valid[s] = sl_cmd_vld;
                s_icb_rsp_ready[s] = sl_rsp_rdy;
            end
        end
    end

    assign m_icb_rsp_rdata = m_rdata;
    assign s_icb_cmd_addr  = {N_SLV{cmd.addr}};
    assign s_icb_cmd_read  = {N_SLV{cmd.read}};
    assign s_icb_cmd_wdata = {N_SLV{cmd.wdata}};
    assign s_icb_cmd_wmask = {N_SLV{cmd.wmask}};

    // Transaction FSM: arbitrate, issue command, route response or error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|m_icb_cmd_valid) begin
                        gnt   <= arb_gnt;
                        sel   <= arb_sel;
                        cnt   <= '0;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!mv)
                        state <= ST_IDLE;          // master withdrew; nothing issued
                    else if (!mapped || tmo)
                        state <= ST_ERR;
                    else if (s_rdy)
                        state <= ST_RSP;
                    else if (TIMEOUT != 0)
                        cnt <= cnt + 1'b1;
                end
                ST_RSP: begin
                    if (s_vld && mr_rdy) begin
                        ptr   <= nxt_ptr;
                        state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (mr_rdy) begin
                        ptr   <= nxt_ptr;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icb_nmxs_rr.sv
// Directed bench for icb_nmxs_rr: 2 masters, 8 slaves, TIMEOUT=16.
module tb_icb_nmxs_rr;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mv, mrd, mrr;
    logic [63:0]  maddr, mwdata;
    logic [7:0]   mwmask;
    logic [1:0]   m_cr, m_rv, m_re;
    logic [63:0]  m_rdata;
    logic [7:0]   s_cv, s_read, s_cr, s_rv, s_re, s_rr;
    logic [255:0] s_addr, s_wdata, s_rdata;
    logic [31:0]  s_wmask;

    int total = 0;
    int bad   = 0;
    int hi;
    logic seen;

    icb_nmxs_rr #(.N_MST(2), .N_SLV(8), .SEL_LSB(28), .SEL_W(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_icb_cmd_valid(mv), .m_icb_cmd_ready(m_cr), .m_icb_cmd_addr(maddr),
        .m_icb_cmd_read(mrd), .m_icb_cmd_wdata(mwdata), .m_icb_cmd_wmask(mwmask),
        .m_icb_rsp_valid(m_rv), .m_icb_rsp_ready(mrr), .m_icb_rsp_err(m_re),
        .m_icb_rsp_rdata(m_rdata),
        .s_icb_cmd_valid(s_cv), .s_icb_cmd_ready(s_cr), .s_icb_cmd_addr(s_addr),
        .s_icb_cmd_read(s_read), .s_icb_cmd_wdata(s_wdata), .s_icb_cmd_wmask(s_wmask),
        .s_icb_rsp_valid(s_rv), .s_icb_rsp_ready(s_rr), .s_icb_rsp_err(s_re),
        .s_icb_rsp_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        mv = '0; mrd = '0; mrr = '0; maddr = '0; mwdata = 64'h1111_2222_3333_4444; mwmask = 8'hFF;
        s_cr = '0; s_rv = '0; s_re = '0;
        for (int s = 0; s < 8; s++) s_rdata[32*s +: 32] = 32'hA000_0000 | s;

        // reset state
        #12;
        chk("rst_m_cmd_ready", m_cr, 0);
        chk("rst_m_rsp_valid", m_rv, 0);
        chk("rst_m_rsp_err", m_re, 0);
        chk("rst_s_cmd_valid", s_cv, 0);
        chk("rst_s_rsp_ready", s_rr, 0);
        chk("rst_m_rdata", m_rdata[31:0], 0);
        nxt();
        rst_n = 1'b1;
        nxt();

        // single read, m1 -> slave 1
        s_cr[1] = 1'b1; s_rv[1] = 1'b1; s_rdata[63:32] = 32'hDEAD_BEEF;
        mrr = 2'b11; mv = 2'b10; mrd = 2'b10; maddr[63:32] = 32'h1000_0004;
        smp();
        chk("rd_idle_cmd_ready", m_cr, 0);
        chk("rd_idle_s_valid", s_cv, 0);
        nxt(); smp();
        chk("rd_cmd_s_valid", s_cv, 8'h02);
        chk("rd_cmd_m_ready", m_cr, 2'b10);
        chk("rd_cmd_addr_bcast0", s_addr[31:0], 32'h1000_0004);
        chk("rd_cmd_addr_bcast7", s_addr[255:224], 32'h1000_0004);
        nxt(); mv = '0; smp();
        chk("rd_rsp_valid", m_rv, 2'b10);
        chk("rd_rsp_rdata", m_rdata[63:32], 32'hDEAD_BEEF);
        chk("rd_rsp_err", m_re, 0);
        chk("rd_rsp_other_rdata", m_rdata[31:0], 0);
        chk("rd_s_rsp_ready", s_rr, 8'h02);
        nxt();
        s_cr = '0; s_rv = '0;

        // round-robin: both masters hammer slave 0
        s_cr[0] = 1'b1; s_rv[0] = 1'b1; s_rdata[31:0] = 32'h00C0_FFEE;
        maddr = '0; mrd = 2'b11; mv = 2'b11;
        for (int t = 0; t < 4; t++) begin
            smp();
            nxt(); smp();
            chk("rr_cmd_grant", m_cr, (t % 2) ? 2'b10 : 2'b01);
            nxt(); smp();
            chk("rr_rsp_grant", m_rv, (t % 2) ? 2'b10 : 2'b01);
            nxt();
        end
        mv = '0; s_cr = '0; s_rv = '0;
        nxt();

        // unmapped address 0x9000_0000 from m0; every slave ready
        s_cr = 8'hFF; s_rv = 8'hFF;
        mv = 2'b01; mrd = 2'b01; maddr[31:0] = 32'h9000_0000;
        smp();
        nxt(); smp();
        chk("um_cmd_ready", m_cr, 2'b01);
        chk("um_cmd_s_valid", s_cv, 0);
        nxt(); mv = '0; smp();
        chk("um_err_valid", m_rv, 2'b01);
        chk("um_err_flag", m_re, 2'b01);
        chk("um_err_rdata", m_rdata[31:0], 0);
        chk("um_err_s_valid", s_cv, 0);
        chk("um_err_cmd_ready", m_cr, 0);
        chk("um_err_s_rsp_ready", s_rr, 0);
        nxt(); smp();
        chk("um_done", m_rv, 0);
        s_cr = '0; s_rv = '0;
        nxt();

        // timeout: slave 2 never ready
        mv = 2'b01; mrd = 2'b00; maddr[31:0] = 32'h2000_0000;
        hi = 0; seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            smp();
            if (s_cv[2]) hi++;
            if (m_cr[0]) begin
                seen = 1'b1;
                chk("to_s_valid_at_ready", s_cv, 0);
            end
            nxt();
        end
        mv = '0;
        chk("to_ready_seen", seen, 1);
        chk("to_valid_cycles", hi, 16);
        smp();
        chk("to_err_valid", m_rv, 2'b01);
        chk("to_err_flag", m_re, 2'b01);
        nxt();

        // response backpressure: m1 -> slave 3, rsp_ready low for 5 cycles
        s_cr[3] = 1'b1; s_rv[3] = 1'b1; s_rdata[127:96] = 32'hCAFE_0003;
        mrr = 2'b00; mv = 2'b10; mrd = 2'b10; maddr[63:32] = 32'h3000_0000;
        smp();
        nxt(); smp();
        chk("bp_cmd_grant", m_cr, 2'b10);
        nxt(); mv = '0;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("bp_hold_valid", m_rv, 2'b10);
            chk("bp_hold_rdata", m_rdata[63:32], 32'hCAFE_0003);
            chk("bp_hold_s_rsp_ready", s_rr, 0);
            nxt();
        end
        mrr = 2'b11;
        smp();
        chk("bp_release_s_rsp_ready", s_rr, 8'h08);
        chk("bp_release_valid", m_rv, 2'b10);
        nxt(); smp();
        chk("bp_done", m_rv, 0);
        s_cr = '0; s_rv = '0;
        nxt();

        // reset mid-RSP after m0 has advanced the pointer to m1
        s_cr[0] = 1'b1; s_rv[0] = 1'b1; maddr = '0; mrr = 2'b11;
        mv = 2'b01;
        nxt(); nxt(); mv = '0; nxt();
        mv = 2'b10; mrr = 2'b00;
        nxt(); nxt(); mv = '0;
        smp();
        chk("rs_in_rsp", m_rv, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_rsp_valid", m_rv, 0);
        chk("rs_async_s_rsp_ready", s_rr, 0);
        chk("rs_async_cmd_ready", m_cr, 0);
        chk("rs_async_s_valid", s_cv, 0);
        nxt();
        rst_n = 1'b1; mv = 2'b11; mrr = 2'b11;
        smp();
        chk("rs_idle_cmd_ready", m_cr, 0);
        nxt(); smp();
        chk("rs_first_grant", m_cr, 2'b01);
        chk("rs_first_s_valid", s_cv, 8'h01);
        nxt();
        mv = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
